// File: rtl/obstacle_engine.sv
// Side-scrolling obstacle game core: bird position, scrolling pipes, scoring,
// collision detection, speed ramp and per-pixel bird/pipe masks.
module obstacle_engine #(
    parameter int unsigned N_PIPES   = 4,
    parameter int unsigned PIPE_W    = 30,
    parameter int unsigned GAP_H     = 120,
    parameter int unsigned GAP_STEP  = 40,
    parameter int unsigned SPACING   = 160,
    parameter int unsigned SCR_W     = 640,
    parameter int unsigned SCR_H     = 480,
    parameter int unsigned BIRD_X    = 50,
    parameter int unsigned BIRD_SZ   = 40,
    parameter int unsigned WIN_SCORE = 30,
    parameter int unsigned T_START   = 1000000,
    parameter int unsigned T_MIN     = 100000,
    parameter int unsigned T_STEP    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       up_key,
    input  logic       down_key,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic [9:0] bird_y,
    output logic       bird_pix,
    output logic       pipe_pix,
    output logic       hit,
    output logic       move_tick
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StDead = 2'd2,
        StWin  = 2'd3
    } state_e;

    // Geometry is carried in 11 bits so that sums like x + PIPE_W never wrap.
    localparam logic [10:0] ScrW     = 11'(SCR_W);
    localparam logic [10:0] PipeW    = 11'(PIPE_W);
    localparam logic [10:0] GapH     = 11'(GAP_H);
    localparam logic [10:0] GapStep  = 11'(GAP_STEP);
    localparam logic [10:0] GapMax   = 11'(SCR_H - GAP_H);
    localparam logic [10:0] BirdX    = 11'(BIRD_X);
    localparam logic [10:0] BirdSz   = 11'(BIRD_SZ);
    localparam logic [10:0] BirdMax  = 11'(SCR_H - BIRD_SZ);
    localparam logic [9:0]  BirdInit = 10'((SCR_H - BIRD_SZ) / 2);
    localparam logic [31:0] TStart   = 32'(T_START);
    localparam logic [31:0] TMin     = 32'(T_MIN);
    localparam logic [31:0] TStep    = 32'(T_STEP);
    localparam logic [8:0]  WinScore = 9'(WIN_SCORE);

    state_e               state_q;
    logic [10:0]          x_q   [N_PIPES];
    logic [10:0]          gap_q [N_PIPES];
    logic [N_PIPES-1:0]   passed_q;
    logic [9:0]           bird_q;
    logic [7:0]           score_q;
    logic [31:0]          period_q;
    logic [31:0]          cnt_q;
    logic [7:0]           lfsr_q;
    logic                 start_q;
    logic                 tick_q;
    logic                 bird_pix_q;
    logic                 pipe_pix_q;

    logic [10:0]          hc_w;
    logic [10:0]          vc_w;
    logic [10:0]          by_w;
    logic [7:0]           lfsr_next;
    logic [10:0]          gap_raw;
    logic [10:0]          gap_new;
    logic                 tick_now;
    logic [N_PIPES-1:0]   wrap;
    logic [N_PIPES-1:0]   pass_new;
    logic [N_PIPES-1:0]   overlap;
    logic [N_PIPES-1:0]   pipe_at_pix;
    logic [8:0]           score_sum;
    logic [7:0]           score_next;
    logic                 bird_at_pix;
    logic                 hit_now;
    logic                 start_rise;

    assign hc_w = {1'b0, hc};
    assign vc_w = {1'b0, vc};
    assign by_w = {1'b0, bird_q};

    // Random source for new gap positions and the current scroll-tick decision.
    always_comb begin
        lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        gap_raw   = 11'(lfsr_q[2:0]) * GapStep;
        gap_new   = (gap_raw > GapMax) ? GapMax : gap_raw;
        tick_now  = (state_q == StPlay) && (cnt_q == period_q);
        start_rise = start && !start_q;
    end

    // Per-pipe wrap, pass, bird overlap and pixel-membership terms.
    always_comb begin
        wrap        = '0;
        pass_new    = '0;
        overlap     = '0;
        pipe_at_pix = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            wrap[i]     = tick_now && (x_q[i] == 11'd0);
            // A pipe leaving the screen this tick is never counted as a pass.
            pass_new[i] = !passed_q[i] && !(tick_now && (x_q[i] == 11'd0)) &&
                          (x_q[i] <= BirdX);
            overlap[i]  = (x_q[i] < BirdX + BirdSz) && (x_q[i] + PipeW > BirdX) &&
                          ((by_w < gap_q[i]) || (by_w + BirdSz > gap_q[i] + GapH));
            pipe_at_pix[i] = (x_q[i] < hc_w) && (hc_w <= x_q[i] + PipeW) &&
                             ((vc_w < gap_q[i]) || (vc_w >= gap_q[i] + GapH));
        end
    end

    // Score after this cycle's new passes, plus collision and bird pixel terms.
    always_comb begin
        score_sum = {1'b0, score_q};
        for (int i = 0; i < N_PIPES; i++) begin
            score_sum = score_sum + 9'(pass_new[i]);
        end
        score_next  = score_sum[8] ? 8'hFF : score_sum[7:0];
        hit_now     = (state_q == StPlay) && ((|overlap) || (by_w == BirdMax));
        bird_at_pix = (hc_w >= BirdX) && (hc_w < BirdX + BirdSz) &&
                      (vc_w >= by_w) && (vc_w < by_w + BirdSz);
    end

    // Game FSM with all registered game state and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            score_q    <= 8'd0;
            bird_q     <= BirdInit;
            passed_q   <= '0;
            period_q   <= TStart;
            cnt_q      <= 32'd0;
            lfsr_q     <= 8'hFF;
            start_q    <= 1'b0;
            tick_q     <= 1'b0;
            bird_pix_q <= 1'b0;
            pipe_pix_q <= 1'b0;
            for (int i = 0; i < N_PIPES; i++) begin
                x_q[i]   <= 11'(SCR_W + i * SPACING);
                gap_q[i] <= 11'd0;
            end
        end else begin
            lfsr_q     <= lfsr_next;
            start_q    <= start;
            tick_q     <= 1'b0;
            bird_pix_q <= (state_q != StIdle) && bird_at_pix;
            pipe_pix_q <= (state_q != StIdle) && (|pipe_at_pix);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StPlay;
                        score_q  <= 8'd0;
                        bird_q   <= BirdInit;
                        passed_q <= '0;
                        period_q <= TStart;
                        cnt_q    <= 32'd0;
                        for (int i = 0; i < N_PIPES; i++) begin
                            x_q[i]   <= 11'(SCR_W + i * SPACING);
                            gap_q[i] <= 11'd0;
                        end
                    end
                end
                StPlay: begin
                    // A collision freezes the world; death wins over a same-cycle win.
                    if (hit_now) begin
                        state_q <= StDead;
                    end else begin
                        score_q <= score_next;
                        if ({1'b0, score_next} >= WinScore) begin
                            state_q <= StWin;
                        end
                        if (tick_now) begin
                            cnt_q    <= 32'd0;
                            tick_q   <= 1'b1;
                            period_q <= (period_q >= TMin + TStep) ? period_q - TStep : TMin;
                            if (up_key) begin
                                if (bird_q != 10'd0) bird_q <= bird_q - 10'd1;
                            end else if (down_key) begin
                                if (by_w < BirdMax) bird_q <= bird_q + 10'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                        for (int i = 0; i < N_PIPES; i++) begin
                            if (wrap[i]) begin
                                x_q[i]      <= ScrW;
                                gap_q[i]    <= gap_new;
                                passed_q[i] <= 1'b0;
                            end else begin
                                if (tick_now) x_q[i] <= x_q[i] - 11'd1;
                                if (pass_new[i]) passed_q[i] <= 1'b1;
                            end
                        end
                    end
                end
                StDead, StWin: begin
                    if (start_rise) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign state     = state_q;
    assign score     = score_q;
    assign bird_y    = bird_q;
    assign bird_pix  = bird_pix_q;
    assign pipe_pix  = pipe_pix_q;
    assign hit       = hit_now;
    assign move_tick = tick_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench for obstacle_engine: a fast game instance for play/score/collision
// scenarios and a second instance for the move-period ramp.
module tb_obstacle_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, up_key, down_key;
    logic [9:0] hc, vc;
    logic [1:0] state;
    logic [7:0] score;
    logic [9:0] bird_y;
    logic       bird_pix, pipe_pix, hit, move_tick;

    logic       start_b;
    logic [1:0] b_state;
    logic [7:0] b_score;
    logic [9:0] b_bird_y;
    logic       b_bird_pix, b_pipe_pix, b_hit, b_tick;

    int n_vec = 0;
    int n_err = 0;
    int n_ticks = 0;
    int cnt;
    int exp_iv [8] = '{65, 55, 45, 35, 25, 15, 5, 5};

    always #5 clk = ~clk;

    obstacle_engine #(
        .T_START   (4),
        .T_MIN     (4),
        .WIN_SCORE (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .up_key    (up_key),
        .down_key  (down_key),
        .hc        (hc),
        .vc        (vc),
        .state     (state),
        .score     (score),
        .bird_y    (bird_y),
        .bird_pix  (bird_pix),
        .pipe_pix  (pipe_pix),
        .hit       (hit),
        .move_tick (move_tick)
    );

    obstacle_engine #(
        .T_START (64),
        .T_MIN   (4),
        .T_STEP  (10)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .up_key    (1'b0),
        .down_key  (1'b0),
        .hc        (10'd0),
        .vc        (10'd0),
        .state     (b_state),
        .score     (b_score),
        .bird_y    (b_bird_y),
        .bird_pix  (b_bird_pix),
        .pipe_pix  (b_pipe_pix),
        .hit       (b_hit),
        .move_tick (b_tick)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock, sampled on the falling edge; counts scroll ticks of the main instance.
    task automatic step();
        @(negedge clk);
        if (move_tick) n_ticks++;
    endtask

    task automatic run_to_tick(input int target);
        int guard = 0;
        while (n_ticks < target && guard < 20000) begin
            step();
            guard++;
        end
        check_val("tick_reach", n_ticks, target);
    endtask

    task automatic pix(input int h, input int v);
        hc = 10'(h);
        vc = 10'(v);
        step();
    endtask

    initial begin
        start = 0; start_b = 0; up_key = 0; down_key = 0; hc = 0; vc = 0;
        reset = 1;
        #2 reset = 0;
        #1;
        check_val("rst_state", state, 0);
        check_val("rst_score", score, 0);
        check_val("rst_bird_y", bird_y, 220);
        check_val("rst_bird_pix", bird_pix, 0);
        check_val("rst_pipe_pix", pipe_pix, 0);
        check_val("rst_hit", hit, 0);
        check_val("rst_tick", move_tick, 0);
        check_val("rst_state_b", b_state, 0);
        step(); step();
        reset = 1;

        // Pixel masks stay low in IDLE even over a pipe or the bird
        pix(650, 200);
        check_val("idle_pipe_pix", pipe_pix, 0);
        pix(60, 230);
        check_val("idle_bird_pix", bird_pix, 0);
        check_val("idle_state", state, 0);

        // Period ramp: tick spacing is P+1 clocks
        start_b = 1;
        step();
        check_val("b_play", b_state, 1);
        for (int k = 0; k < 8; k++) begin
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (!b_tick && cnt < 200);
            check_val($sformatf("b_interval%0d", k + 1), cnt, exp_iv[k]);
        end
        start_b = 0;

        // Game 1: first tick latency, pipe mask, key handling, scoring, win
        start = 1;
        step();
        check_val("g1_state", state, 1);
        n_ticks = 0;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!move_tick && cnt < 20);
        check_val("first_tick_lat", cnt, 5);
        pix(640, 200);
        check_val("pipe_left_in", pipe_pix, 1);
        pix(639, 200);
        check_val("pipe_left_out", pipe_pix, 0);
        pix(669, 120);
        check_val("pipe_right_in", pipe_pix, 1);
        pix(670, 200);
        check_val("pipe_right_out", pipe_pix, 0);
        up_key = 1; down_key = 1;
        run_to_tick(2);
        check_val("up_priority", bird_y, 219);
        down_key = 0;
        run_to_tick(100);
        pix(550, 60);
        check_val("gap_mid", pipe_pix, 0);
        pix(550, 119);
        check_val("gap_bottom_row", pipe_pix, 0);
        pix(550, 120);
        check_val("below_gap", pipe_pix, 1);
        run_to_tick(219);
        check_val("bird_at_2", bird_y, 2);
        run_to_tick(220);
        check_val("bird_at_1", bird_y, 1);
        run_to_tick(221);
        check_val("bird_at_0", bird_y, 0);
        run_to_tick(222);
        check_val("bird_sat_0", bird_y, 0);
        run_to_tick(589);
        check_val("pre_pass", score, 0);
        run_to_tick(590);
        check_val("pass_same_cycle", score, 0);
        step();
        check_val("pass1", score, 1);
        run_to_tick(700);
        check_val("no_rescore", score, 1);
        check_val("still_play", state, 1);
        run_to_tick(750);
        step();
        check_val("win_score", score, 2);
        check_val("win_state", state, 3);
        step(); step();
        check_val("win_hold", state, 3);
        start = 0;
        step();
        start = 1;
        step();
        check_val("win_to_idle", state, 0);
        check_val("idle_score_kept", score, 2);
        step();
        check_val("replay_state", state, 1);
        check_val("replay_score", score, 0);
        check_val("replay_bird", bird_y, 220);
        n_ticks = 0;

        // Game 2: drive to the floor
        up_key = 0; down_key = 1;
        run_to_tick(219);
        check_val("floor_m1_bird", bird_y, 439);
        check_val("floor_m1_hit", hit, 0);
        run_to_tick(220);
        check_val("floor_bird", bird_y, 440);
        check_val("floor_hit", hit, 1);
        check_val("floor_hit_state", state, 1);
        step();
        check_val("floor_dead", state, 2);
        down_key = 0;
        start = 0;
        step();
        start = 1;
        step();
        check_val("dead_to_idle", state, 0);
        step();
        check_val("g3_state", state, 1);
        n_ticks = 0;

        // Game 3: bird mask, then pipe 0 (gap at top) runs into the idle bird
        pix(50, 220);
        check_val("bird_tl", bird_pix, 1);
        pix(89, 259);
        check_val("bird_br", bird_pix, 1);
        pix(90, 220);
        check_val("bird_right_out", bird_pix, 0);
        pix(50, 260);
        check_val("bird_below_out", bird_pix, 0);
        run_to_tick(550);
        check_val("pipe_x90_hit", hit, 0);
        run_to_tick(551);
        check_val("pipe_x89_hit", hit, 1);
        step();
        check_val("pipe_dead", state, 2);
        check_val("pipe_dead_score", score, 0);

        // Game 4: asynchronous reset in the middle of play
        start = 0;
        step();
        start = 1;
        step();
        step();
        check_val("g4_state", state, 1);
        n_ticks = 0;
        up_key = 1;
        run_to_tick(3);
        check_val("g4_bird", bird_y, 217);
        reset = 0;
        #1;
        check_val("async_state", state, 0);
        check_val("async_tick", move_tick, 0);
        check_val("async_bird", bird_y, 220);
        check_val("async_score", score, 0);
        @(negedge clk);
        reset = 1;
        up_key = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
